// File: rtl/ps_pkg.sv
// Shared types and constants for the permutation-service router.
// Entry struct widths describe the default router configuration.
package ps_pkg;
   localparam int PS_DATA_W = 8;
   localparam int PS_NUM_CH = 4;
   localparam int PS_CH_W   = $clog2(PS_NUM_CH);
   localparam int NOC_NOP   = 0;
   localparam int HDR_BIT   = PS_DATA_W - 1;

   typedef enum logic [1:0] {I_IDLE, I_LEN, I_PAY, I_DROP} in_state_t;
   typedef enum logic [1:0] {O_IDLE, O_HDR, O_DATA} out_state_t;

   typedef struct packed {
      logic [PS_CH_W-1:0]   ch;
      logic                 last;
      logic [PS_DATA_W-1:0] data;
   } ps_entry_t;
endpackage

// File: rtl/ps_fifo.sv
// Synchronous FIFO; head is the oldest entry, readable the cycle after it is written.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module ps_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [AW:0]      cnt_q;
   logic             do_push, do_pop;

   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem_q[rd_q];

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= push_dat;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/ps_router.sv
// NOC byte port to NUM_CH device channels: parses/steers inbound packets through a FIFO,
// round-robin frames channel responses back onto the NOC. Inbound has no backpressure.
module ps_router
   import ps_pkg::*;
#(
   parameter int DATA_W     = PS_DATA_W,
   parameter int NUM_CH     = PS_NUM_CH,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     noc_to_dev_ctl,
   input  logic [DATA_W-1:0]        noc_to_dev_data,
   output logic                     noc_from_dev_ctl,
   output logic [DATA_W-1:0]        noc_from_dev_data,
   output logic [NUM_CH-1:0]        ch_valid,
   output logic [DATA_W-1:0]        ch_data,
   output logic                     ch_last,
   input  logic [NUM_CH-1:0]        ch_ready,
   input  logic [NUM_CH-1:0]        rsp_valid,
   input  logic [NUM_CH*DATA_W-1:0] rsp_data,
   input  logic [NUM_CH-1:0]        rsp_last,
   output logic [NUM_CH-1:0]        rsp_ready,
   output logic                     err_overflow,
   output logic                     err_badch,
   output logic                     err_abort
);
   localparam int CH_W = $clog2(NUM_CH);
   localparam int HDR  = DATA_W - 1;
   localparam int EW   = CH_W + 1 + DATA_W;
   localparam logic [DATA_W:0] REM_ONE = (DATA_W+1)'(1);

   typedef struct packed {
      logic [CH_W-1:0]   ch;
      logic              last;
      logic [DATA_W-1:0] data;
   } entry_t;

   in_state_t         in_st_q;
   logic [CH_W-1:0]   in_ch_q;
   logic              drop_q;
   logic [DATA_W:0]   rem_q;
   logic              err_ovf_q, err_bad_q, err_abt_q;
   logic              is_hdr, hdr_bad, push, pop, full, empty;
   logic [DATA_W-1:0] hdr_ch;
   entry_t            push_dat, head;

   // The range check uses the whole field below the header bit, not just CH_W bits.
   assign hdr_ch   = {1'b0, noc_to_dev_data[HDR-1:0]};
   assign is_hdr   = noc_to_dev_ctl & noc_to_dev_data[HDR];
   assign hdr_bad  = (hdr_ch >= DATA_W'(NUM_CH));
   assign push     = (in_st_q == I_PAY) & ~noc_to_dev_ctl;
   assign push_dat = {in_ch_q, (rem_q == REM_ONE), noc_to_dev_data};

   always_ff @(posedge clk) begin
      if (!reset) begin
         in_st_q   <= I_IDLE;
         in_ch_q   <= '0;
         drop_q    <= 1'b0;
         rem_q     <= '0;
         err_ovf_q <= 1'b0;
         err_bad_q <= 1'b0;
         err_abt_q <= 1'b0;
      end else begin
         if (push && full && !pop) err_ovf_q <= 1'b1;
         if (noc_to_dev_ctl) begin
            // A control byte ends any packet in progress, then is parsed as if idle.
            if (in_st_q != I_IDLE) err_abt_q <= 1'b1;
            if (is_hdr) begin
               in_st_q <= I_LEN;
               in_ch_q <= noc_to_dev_data[CH_W-1:0];
               drop_q  <= hdr_bad;
               if (hdr_bad) err_bad_q <= 1'b1;
            end else begin
               in_st_q <= I_IDLE;
            end
         end else begin
            case (in_st_q)
               I_LEN: begin
                  rem_q   <= (noc_to_dev_data == '0) ? {1'b1, {DATA_W{1'b0}}}
                                                     : {1'b0, noc_to_dev_data};
                  in_st_q <= drop_q ? I_DROP : I_PAY;
               end
               I_PAY, I_DROP: begin
                  rem_q <= rem_q - REM_ONE;
                  if (rem_q == REM_ONE) in_st_q <= I_IDLE;
               end
               default: ;
            endcase
         end
      end
   end

   ps_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .push_dat (push_dat),
      .pop      (pop),
      .full     (full),
      .empty    (empty),
      .head     (head)
   );

   assign pop          = ~empty & ch_ready[head.ch];
   assign ch_valid     = empty ? '0 : (NUM_CH'(1) << head.ch);
   assign ch_data      = head.data;
   assign ch_last      = ~empty & head.last;
   assign err_overflow = err_ovf_q;
   assign err_badch    = err_bad_q;
   assign err_abort    = err_abt_q;

   out_state_t        out_st_q;
   logic [CH_W-1:0]   rr_q, nxt_g, idx;
   logic              noc_ctl_q;
   logic [DATA_W-1:0] noc_dat_q, hdr_out;

   // Scan farthest-to-nearest so the nearest requester after rr_q wins.
   always_comb begin
      nxt_g = rr_q;
      idx   = '0;
      for (int i = NUM_CH; i >= 1; i--) begin
         idx = CH_W'((int'(rr_q) + i) % NUM_CH);
         if (rsp_valid[idx]) nxt_g = idx;
      end
   end

   always_comb begin
      hdr_out           = '0;
      hdr_out[HDR]      = 1'b1;
      hdr_out[CH_W-1:0] = rr_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         out_st_q  <= O_IDLE;
         rr_q      <= CH_W'(NUM_CH - 1);
         noc_ctl_q <= 1'b1;
         noc_dat_q <= DATA_W'(NOC_NOP);
      end else begin
         noc_ctl_q <= 1'b1;
         noc_dat_q <= DATA_W'(NOC_NOP);
         case (out_st_q)
            O_IDLE: if (|rsp_valid) begin
               rr_q     <= nxt_g;
               out_st_q <= O_HDR;
            end
            O_HDR: begin
               noc_dat_q <= hdr_out;
               out_st_q  <= O_DATA;
            end
            O_DATA: if (rsp_valid[rr_q]) begin
               noc_ctl_q <= 1'b0;
               noc_dat_q <= rsp_data[int'(rr_q)*DATA_W +: DATA_W];
               if (rsp_last[rr_q]) out_st_q <= O_IDLE;
            end
            default: out_st_q <= O_IDLE;
         endcase
      end
   end

   assign rsp_ready         = (out_st_q == O_DATA) ? (NUM_CH'(1) << rr_q) : '0;
   assign noc_from_dev_ctl  = noc_ctl_q;
   assign noc_from_dev_data = noc_dat_q;
endmodule

// File: tb/tb_ps_router.sv
// Directed bench for ps_router: scoreboards on the device side and the NOC response side.
module tb_ps_router;
   import ps_pkg::*;

   localparam int NCH = 4;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           noc_to_dev_ctl = 1'b1;
   logic [7:0]     noc_to_dev_data = 8'h00;
   logic           noc_from_dev_ctl;
   logic [7:0]     noc_from_dev_data;
   logic [NCH-1:0] ch_valid;
   logic [7:0]     ch_data;
   logic           ch_last;
   logic [NCH-1:0] ch_ready = '0;
   logic [NCH-1:0] rsp_valid;
   logic [NCH*8-1:0] rsp_data;
   logic [NCH-1:0] rsp_last;
   logic [NCH-1:0] rsp_ready;
   logic           err_overflow, err_badch, err_abort;

   int n_assert = 0;
   int n_fail   = 0;

   ps_entry_t  exp_ch_q [$];
   logic [8:0] exp_noc_q [$];
   logic [8:0] rq [NCH][$];
   logic [8:0] obs_log [$];
   logic       log_en = 1'b0;
   logic [NCH-1:0] hs;
   ps_entry_t  mon_e;
   logic [8:0] arb_exp [12];

   ps_router #(.DATA_W(8), .NUM_CH(NCH), .FIFO_DEPTH(8)) dut (
      .clk(clk), .reset(reset),
      .noc_to_dev_ctl(noc_to_dev_ctl), .noc_to_dev_data(noc_to_dev_data),
      .noc_from_dev_ctl(noc_from_dev_ctl), .noc_from_dev_data(noc_from_dev_data),
      .ch_valid(ch_valid), .ch_data(ch_data), .ch_last(ch_last), .ch_ready(ch_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_ready(rsp_ready),
      .err_overflow(err_overflow), .err_badch(err_badch), .err_abort(err_abort)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic c, input logic [7:0] d);
      noc_to_dev_ctl  = c;
      noc_to_dev_data = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) send(1'b1, 8'h00);
   endtask

   task automatic exp_ch(input int ch, input logic last, input logic [7:0] d);
      ps_entry_t e;
      e.ch = PS_CH_W'(ch);
      e.last = last;
      e.data = d;
      exp_ch_q.push_back(e);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      noc_to_dev_ctl = 1'b1;
      noc_to_dev_data = 8'h00;
      ch_ready = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   // Response sources: handshake seen at negedge, consumed and redriven after the edge.
   always @(negedge clk) hs = rsp_ready & rsp_valid;

   always @(posedge clk) begin
      #1;
      for (int c = 0; c < NCH; c++) begin
         if (hs[c] === 1'b1 && rq[c].size() > 0) void'(rq[c].pop_front());
         if (rq[c].size() > 0) begin
            rsp_valid[c]       = 1'b1;
            rsp_data[c*8 +: 8] = rq[c][0][7:0];
            rsp_last[c]        = rq[c][0][8];
         end else begin
            rsp_valid[c]       = 1'b0;
            rsp_data[c*8 +: 8] = 8'h00;
            rsp_last[c]        = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (reset && (ch_valid & ch_ready) != '0) begin
         if (exp_ch_q.size() == 0) begin
            chk("ch_unexpected_byte", 32'(ch_data), 32'hFFFF_FFFF);
         end else begin
            mon_e = exp_ch_q.pop_front();
            chk("ch_valid", 32'(ch_valid), 32'(1) << mon_e.ch);
            chk("ch_last", 32'(ch_last), 32'(mon_e.last));
            chk("ch_data", 32'(ch_data), 32'(mon_e.data));
         end
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         if (log_en) obs_log.push_back({noc_from_dev_ctl, noc_from_dev_data});
         if (!(noc_from_dev_ctl && noc_from_dev_data == 8'h00)) begin
            if (exp_noc_q.size() == 0)
               chk("noc_unexpected_byte", 32'({noc_from_dev_ctl, noc_from_dev_data}), 32'hFFFF_FFFF);
            else
               chk("noc_byte", 32'({noc_from_dev_ctl, noc_from_dev_data}), 32'(exp_noc_q.pop_front()));
         end
      end
   end

   initial begin
      int start;
      arb_exp = '{9'h180, 9'h0C1, 9'h0C2, 9'h100, 9'h183, 9'h0D1, 9'h0D2,
                  9'h100, 9'h180, 9'h0C5, 9'h0C6, 9'h100};

      // Reset state
      do_reset();
      @(negedge clk);
      chk("rst_noc_ctl", 32'(noc_from_dev_ctl), 32'd1);
      chk("rst_noc_data", 32'(noc_from_dev_data), 32'd0);
      chk("rst_ch_valid", 32'(ch_valid), 32'd0);
      chk("rst_rsp_ready", 32'(rsp_ready), 32'd0);
      chk("rst_errs", 32'({err_overflow, err_badch, err_abort}), 32'd0);

      // Basic packet to ch2
      ch_ready = 4'b0100;
      send(1'b1, 8'h82);
      send(1'b0, 8'h03);
      exp_ch(2, 1'b0, 8'hA1);
      send(1'b0, 8'hA1);
      @(negedge clk);
      chk("basic_latency_valid", 32'(ch_valid), 32'h4);
      exp_ch(2, 1'b0, 8'hA2);
      send(1'b0, 8'hA2);
      exp_ch(2, 1'b1, 8'hA3);
      send(1'b0, 8'hA3);
      idle(3);
      chk("basic_drained", 32'(exp_ch_q.size()), 32'd0);
      chk("basic_errs", 32'({err_overflow, err_badch, err_abort}), 32'd0);

      // Backpressure and overflow
      do_reset();
      send(1'b1, 8'h81);
      send(1'b0, 8'h0A);
      for (int i = 0; i < 10; i++) begin
         if (i < 8) exp_ch(1, 1'b0, 8'hD0 + 8'(i));
         send(1'b0, 8'hD0 + 8'(i));
      end
      @(negedge clk);
      chk("ovf_flag", 32'(err_overflow), 32'd1);
      chk("ovf_held_valid", 32'(ch_valid), 32'h2);
      ch_ready = 4'b0010;
      idle(10);
      chk("ovf_drained", 32'(exp_ch_q.size()), 32'd0);
      chk("ovf_empty_valid", 32'(ch_valid), 32'd0);

      // Bad channel then a good packet
      do_reset();
      ch_ready = 4'b0001;
      send(1'b1, 8'h85);
      send(1'b0, 8'h02);
      send(1'b0, 8'h11);
      send(1'b0, 8'h22);
      @(negedge clk);
      chk("badch_flag", 32'(err_badch), 32'd1);
      chk("badch_nothing_pushed", 32'(ch_valid), 32'd0);
      send(1'b1, 8'h80);
      send(1'b0, 8'h01);
      exp_ch(0, 1'b1, 8'h55);
      send(1'b0, 8'h55);
      idle(3);
      chk("badch_good_drained", 32'(exp_ch_q.size()), 32'd0);
      chk("badch_no_abort", 32'(err_abort), 32'd0);

      // Abort mid-payload
      do_reset();
      ch_ready = 4'b0011;
      send(1'b1, 8'h80);
      send(1'b0, 8'h04);
      exp_ch(0, 1'b0, 8'hB1);
      send(1'b0, 8'hB1);
      exp_ch(0, 1'b0, 8'hB2);
      send(1'b0, 8'hB2);
      send(1'b1, 8'h81);
      send(1'b0, 8'h01);
      exp_ch(1, 1'b1, 8'h77);
      send(1'b0, 8'h77);
      idle(3);
      chk("abort_flag", 32'(err_abort), 32'd1);
      chk("abort_other_errs", 32'({err_overflow, err_badch}), 32'd0);
      chk("abort_drained", 32'(exp_ch_q.size()), 32'd0);

      // Response arbitration: ch0 has two packets, ch3 one
      do_reset();
      obs_log.delete();
      log_en = 1'b1;
      rq[0].push_back(9'h0C1); rq[0].push_back(9'h1C2);
      rq[0].push_back(9'h0C5); rq[0].push_back(9'h1C6);
      rq[3].push_back(9'h0D1); rq[3].push_back(9'h1D2);
      exp_noc_q.push_back(9'h180); exp_noc_q.push_back(9'h0C1); exp_noc_q.push_back(9'h0C2);
      exp_noc_q.push_back(9'h183); exp_noc_q.push_back(9'h0D1); exp_noc_q.push_back(9'h0D2);
      exp_noc_q.push_back(9'h180); exp_noc_q.push_back(9'h0C5); exp_noc_q.push_back(9'h0C6);
      idle(20);
      log_en = 1'b0;
      start = 0;
      while (start < obs_log.size() && obs_log[start] == 9'h100) start++;
      for (int k = 0; k < 12; k++) begin
         if (start + k < obs_log.size())
            chk($sformatf("arb_seq[%0d]", k), 32'(obs_log[start + k]), 32'(arb_exp[k]));
         else
            chk("arb_seq_length", 32'(obs_log.size()), 32'(start + 12));
      end
      chk("arb_scoreboard_empty", 32'(exp_noc_q.size()), 32'd0);
      chk("arb_rsp_ready_idle", 32'(rsp_ready), 32'd0);

      // Reset mid-payload
      do_reset();
      send(1'b1, 8'h80);
      send(1'b1, 8'h82);
      send(1'b0, 8'h05);
      send(1'b0, 8'hE1);
      send(1'b0, 8'hE2);
      send(1'b0, 8'hE3);
      @(negedge clk);
      chk("midrst_pre_valid", 32'(ch_valid), 32'h4);
      chk("midrst_pre_abort", 32'(err_abort), 32'd1);
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_ch_valid", 32'(ch_valid), 32'd0);
      chk("midrst_noc", 32'({noc_from_dev_ctl, noc_from_dev_data}), 32'h100);
      chk("midrst_errs", 32'({err_overflow, err_badch, err_abort}), 32'd0);
      send(1'b0, 8'hE4);
      ch_ready = '1;
      idle(3);
      chk("midrst_discarded", 32'(ch_valid), 32'd0);
      chk("final_ch_scoreboard", 32'(exp_ch_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/ps_router.md
Name: ps_router

Overview:
- Parametrised successor to the single-device permutation-service shim.
- Sits between one NOC byte port (NOCI-style ctl/data pair) and NUM_CH device channels, such as permutation engines.
- Parses inbound NOC packets, buffers payload, and steers each packet to the addressed channel.
- Round-robin arbitrates channel responses back onto the NOC as framed packets.

Parameters:
- DATA_W, 8: NOC and channel data width; must be >= CH_W+1.
- NUM_CH, 4: number of device channels, 2..16.
- FIFO_DEPTH, 8: inbound payload FIFO entries; power of two.
- CH_W, $clog2(NUM_CH): localparam, channel-id width.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset: reset==0 at a rising edge resets the block.
- noc_to_dev_ctl  in  1  1 = control byte, 0 = data byte.
- noc_to_dev_data  in  DATA_W  inbound byte.
- noc_from_dev_ctl  out  1  outbound control flag.
- noc_from_dev_data  out  DATA_W  outbound byte.
- ch_valid  out  NUM_CH  one-hot valid toward the devices.
- ch_data  out  DATA_W  shared payload to the devices.
- ch_last  out  1  last byte of packet.
- ch_ready  in  NUM_CH  device accepts.
- rsp_valid  in  NUM_CH  device response valid.
- rsp_data  in  NUM_CH*DATA_W  response bytes; channel i occupies slice [i*DATA_W +: DATA_W].
- rsp_last  in  NUM_CH  last response byte.
- rsp_ready  out  NUM_CH  one-hot response accept.
- err_overflow  out  1  sticky: payload lost to a full FIFO.
- err_badch  out  1  sticky: header addressed channel >= NUM_CH.
- err_abort  out  1  sticky: control byte arrived mid-payload.

Behaviour:
- Reset values:
  - noc_from_dev_ctl=1, noc_from_dev_data=0 (NOP).
  - ch_valid=0, rsp_ready=0, all err flags=0.
  - FIFO empty.
  - Inbound FSM in I_IDLE, outbound FSM in O_IDLE.
  - Round-robin pointer = NUM_CH-1, so channel 0 wins first.
- Reset mid-operation: any in-flight packet is discarded and the FIFO is flushed.
- Inbound FSM, one NOC byte per cycle, no backpressure:
  - I_IDLE:
    - ctl=1 with data==0 is a NOP; stay.
    - ctl=1 with data[DATA_W-1]=1 is a header: latch ch=data[CH_W-1:0] and go to I_LEN. If ch>=NUM_CH, set err_badch and go to I_LEN with a drop flag set.
    - ctl=0 bytes are ignored.
  - I_LEN:
    - ctl=0: latch L=data, where 0 means 256 bytes; go to I_PAY, or I_DROP if the drop flag is set.
    - ctl=1: set err_abort and reprocess that byte as in I_IDLE.
  - I_PAY:
    - Each ctl=0 byte pushes {ch, last=(remaining==1), data} into the FIFO and decrements remaining.
    - After the last byte, go to I_IDLE.
    - ctl=1: set err_abort and reprocess the byte as in I_IDLE. No synthetic last byte is pushed.
  - I_DROP: consume L ctl=0 bytes without pushing, then go to I_IDLE. ctl=1 handling matches I_PAY.
- FIFO full on push: drop the byte, set err_overflow, continue counting. Push and pop in the same cycle is legal when full.
- Device side:
  - FIFO head drives ch_data/ch_last, with ch_valid[head.ch]=1 while the FIFO is non-empty.
  - Pop occurs when ch_valid & ch_ready for the head channel.
  - Data is visible the cycle after it is written into an empty FIFO; latency from NOC byte to ch_valid is 1 cycle.
- Outbound FSM; all NOC outputs are registered:
  - O_IDLE:
    - Drive NOP.
    - If any rsp_valid is set, grant g = first set bit after the RR pointer, update the pointer to g, and go to O_HDR.
  - O_HDR: drive ctl=1, data={1'b1, zeros, g[CH_W-1:0]} for one cycle; go to O_DATA.
  - O_DATA:
    - rsp_ready[g]=1 combinationally.
    - If rsp_valid[g], drive ctl=0 with that byte next cycle.
    - Otherwise drive NOP; NOP is legal filler inside a response.
    - Accepting rsp_last[g] returns the FSM to O_IDLE.
  - No other channel is granted until the current packet's last byte.
  - Minimum gap between response packets: 1 NOP cycle (O_IDLE).
- Inbound and outbound paths are fully independent and concurrent.
- Error flags clear only on reset.

Decomposition:
- Package ps_pkg holds:
  - In-state enum {I_IDLE, I_LEN, I_PAY, I_DROP}.
  - Out-state enum {O_IDLE, O_HDR, O_DATA}.
  - Constants NOC_NOP=0 and HDR_BIT=DATA_W-1.
  - FIFO entry struct type, parameterised via localparam widths.
- Sub-module ps_fifo: synchronous FIFO with parameters WIDTH and DEPTH, and ports push/pop/full/empty/head.

Test Plan:
- Basic packet: header 0x82, len 3, data 0xA1/0xA2/0xA3 with ch_ready[2]=1 → ch_valid=0b0100 on three consecutive cycles with ch_last on 0xA3; no errors.
- Backpressure and overflow: FIFO_DEPTH=8, ch_ready=0, header 0x81, len 10, 10 bytes → first 8 bytes held and the next 2 dropped with err_overflow=1; raising ch_ready drains 8 bytes, and ch_last never asserts.
- Bad channel: NUM_CH=4, header 0x85, len 2, 2 bytes → nothing pushed, err_badch=1; a following header 0x80, len 1, 0x55 is delivered to ch0 with ch_last.
- Abort: header 0x80, len 4, 2 bytes, then header 0x81, len 1, 0x77 → err_abort=1, ch0 receives 2 bytes without last, ch1 receives 0x77 with last.
- Response arbitration: rsp_valid=0b1001 with 2-byte packets on each → NOC output is NOP, 0x80, b0, b1, NOP, 0x83, b0, b1; a repeat request grants ch0 again only after ch3.
- Reset mid-payload: drive reset=0 for one clock during I_PAY with 3 bytes queued → FIFO empty, ch_valid=0, NOC output NOP, error flags 0 on the next cycle.
